i2s_clk_gen: RTL
================

Name: i2s_clk_gen

Overview:
- Parametrised successor to the fixed single-output audio clock divider.
- Derives the I2S bit clock (bclk) and word-select clock (lrclk) from the 50 MHz system clock.
- Bclk half-period and bits-per-channel are runtime-programmable through a shadow register. New settings apply only at frame boundaries.
- Emits single-cycle strobes (bclk edges, frame start) so downstream serializers stay in the clk_in domain.

Parameters:
- DIV_W, 8, width of the half-period divisor.
- DEF_HALF, 21, reset value of the active half-period divisor; bclk half-period = DEF_HALF+1 clk_in cycles.
- BITS_W, 6, width of the bits-per-channel field.
- DEF_BITS, 32, reset value of the active bits per channel.

Ports:
- clk_in  input  1  system clock (50 MHz on DE2).
- ar  input  1  asynchronous active-low reset.
- en  input  1  run enable.
- cfg_half  input  DIV_W  requested half-period divisor.
- cfg_bits  input  BITS_W  requested bits per channel.
- cfg_load  input  1  one-cycle strobe; captures cfg_half/cfg_bits into the shadow register.
- bclk  output  1  bit clock, registered.
- lrclk  output  1  word select, registered; 0 = left, 1 = right.
- bclk_rise  output  1  one-cycle strobe, same edge as bclk 0->1.
- bclk_fall  output  1  one-cycle strobe, same edge as bclk 1->0.
- frame_start  output  1  one-cycle strobe at the start of each left channel.
- busy  output  1  high while running.
- cfg_pending  output  1  shadow holds values not yet applied.

Behaviour:
- Reset (ar low, asynchronous):
  - bclk, lrclk, all strobes, busy, cfg_pending = 0.
  - Counters = 0.
  - Active config = DEF_HALF/DEF_BITS.
  - State = IDLE.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Outputs parked low.
  - If cfg_pending, apply the shadow to the active config on the next clk_in edge and clear cfg_pending.
  - en=1 -> RUN, busy=1, frame_start pulses that same edge; divide counter starts at 0.
- RUN/DRAIN divide counter:
  - Each clk_in edge: if count >= active_half, then toggle bclk and set count=0; else count+1.
  - active_half = 0 gives bclk = clk_in/2.
  - bclk_rise/bclk_fall are registered alongside the toggle and are high exactly in the cycle bclk changes.
- Bit counter:
  - Increments on each bclk falling toggle.
  - When it reaches active_bits-1 at a falling toggle: it wraps to 0 and lrclk toggles on the same edge.
- Frame boundary = falling toggle where lrclk goes 1->0.
  - frame_start pulses with it.
  - If cfg_pending, the shadow is copied to the active config on that edge, cfg_pending clears, and new timing is used from the next count.
- Config range:
  - active_bits values < 2 are clamped to 2 when applied.
  - Full-scale divisor (all ones) is legal.
- en dropped in RUN -> DRAIN.
  - Clocks continue to the next frame boundary.
  - On that edge: bclk=0, lrclk=0, counters=0, busy=0, state IDLE, no frame_start.
- en reasserted during DRAIN: return to RUN without interruption.
- cfg_load behaviour:
  - Overwrites the shadow and sets cfg_pending in any state.
  - If a pending update is replaced before a boundary, only the last value is applied.
  - cfg_load on the same edge as a frame boundary: the old shadow is applied and the new value stays pending.
- Timing: one full frame = 2*active_bits*2*(active_half+1) clk_in cycles.
- Latency: first bclk rise occurs active_half+1 cycles after leaving IDLE.
- No combinational paths from inputs to outputs.

Optional Feature:
- Macro I2S_CLKGEN_MCLK_EN.
- When defined:
  - Adds parameter MCLK_HALF (default 1) and output port mclk.
  - mclk is a free-running divider: half-period = MCLK_HALF+1 clk_in cycles.
  - mclk runs whenever ar is high, independent of en/state.
  - Reset value of mclk is 0.
- When undefined: no mclk port or logic; all other behaviour is identical.

Test Plan:
- Reset defaults, en=1 -> bclk period 44 clk_in cycles (22 high / 22 low); lrclk period 64 bclk = 2816 cycles; frame_start every 2816 cycles; bclk_rise count per frame = 64.
- cfg_half=0, cfg_bits=2 loaded mid-frame -> old timing holds until the lrclk 1->0 edge. After it: bclk = clk_in/2, lrclk period 8 cycles, cfg_pending falls on that edge.
- cfg_bits=1 -> clamped to 2 when applied; cfg_bits=0 -> also 2; lrclk period = 4 bclk.
- en deasserted at bit 5 of the right channel -> bclk continues until bit counter wraps. Then bclk=lrclk=0, busy=0, no further strobes; re-enable -> first bclk_rise after active_half+1 cycles.
- ar pulsed low mid-frame with cfg_pending=1 -> all outputs 0 immediately (asynchronous), pending cleared, active config = 21/32.
- With I2S_CLKGEN_MCLK_EN, MCLK_HALF=1 -> mclk period 4 cycles, toggling while en=0; absent macro, the build has no mclk port.

Source files
------------

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: I2S bit clock / word select generator running in the clk_in domain.
// bclk half-period and bits-per-channel are programmable through a shadow
// register. Shadow contents are applied only at frame boundaries, or in IDLE.
// Optional free-running master clock output is enabled by defining the macro
// I2S_CLKGEN_MCLK_EN.
//
// state | meaning
// IDLE  | outputs parked low, pending config applied immediately
// RUN   | bclk/lrclk running, en high
// DRAIN | en dropped, clocks run on to the next frame boundary then stop
module i2s_clk_gen #(
  parameter int DIV_W     = 8,
  parameter int DEF_HALF  = 21,
  parameter int BITS_W    = 6,
  parameter int DEF_BITS  = 32
`ifdef I2S_CLKGEN_MCLK_EN
  ,
  parameter int MCLK_HALF = 1
`endif
) (
  input  logic              clk_in,
  input  logic              ar,
  input  logic              en,
  input  logic [DIV_W-1:0]  cfg_half,
  input  logic [BITS_W-1:0] cfg_bits,
  input  logic              cfg_load,
  output logic              bclk,
  output logic              lrclk,
  output logic              bclk_rise,
  output logic              bclk_fall,
  output logic              frame_start,
  output logic              busy,
  output logic              cfg_pending
`ifdef I2S_CLKGEN_MCLK_EN
  ,
  output logic              mclk
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt;
  logic [BITS_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]    active_half, shadow_half;
  logic [BITS_W-1:0]   active_bits, shadow_bits;
  logic [BITS_W-1:0]   shadow_bits_clamped;
  logic                running, toggle, boundary, start, stop, apply;

  // Fewer than two bits per channel cannot form a frame, so clamp on apply.
  assign shadow_bits_clamped = (shadow_bits < BITS_W'(2)) ? BITS_W'(2) : shadow_bits;

  // FSM state register.
  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the control decisions taken on this edge.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    stop     = 1'b0;
    apply    = 1'b0;
    running  = (state_q != IDLE);
    toggle   = running && (div_cnt >= active_half);
    boundary = toggle && bclk && lrclk && (bit_cnt == active_bits - BITS_W'(1));
    case (state_q)
      IDLE: begin
        apply = cfg_pending;
        if (en) begin
          start   = 1'b1;
          state_d = RUN;
        end
      end
      RUN, DRAIN: begin
        apply = boundary && cfg_pending;
        if (boundary && !en) begin
          stop    = 1'b1;
          state_d = IDLE;
        end else if (!en) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow/active configuration; a load coinciding with an apply stays pending.
  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      active_half <= DIV_W'(DEF_HALF);
      active_bits <= BITS_W'(DEF_BITS);
      shadow_half <= DIV_W'(DEF_HALF);
      shadow_bits <= BITS_W'(DEF_BITS);
      cfg_pending <= 1'b0;
    end else begin
      if (apply) begin
        active_half <= shadow_half;
        active_bits <= shadow_bits_clamped;
      end
      if (cfg_load) begin
        shadow_half <= cfg_half;
        shadow_bits <= cfg_bits;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  // Divider, bit counter, clocks and strobes.
  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      bclk_rise   <= 1'b0;
      bclk_fall   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      bclk_rise   <= 1'b0;
      bclk_fall   <= 1'b0;
      frame_start <= 1'b0;
      if (start) begin
        busy        <= 1'b1;
        frame_start <= 1'b1;
        div_cnt     <= '0;
        bit_cnt     <= '0;
        bclk        <= 1'b0;
        lrclk       <= 1'b0;
      end else if (running) begin
        if (toggle) begin
          div_cnt   <= '0;
          bclk      <= ~bclk;
          bclk_rise <= ~bclk;
          bclk_fall <= bclk;
          if (bclk) begin
            if (bit_cnt == active_bits - BITS_W'(1)) begin
              bit_cnt <= '0;
              lrclk   <= ~lrclk;
            end else begin
              bit_cnt <= bit_cnt + BITS_W'(1);
            end
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
        if (stop) begin
          busy    <= 1'b0;
          bclk    <= 1'b0;
          lrclk   <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
        end else if (boundary) begin
          frame_start <= 1'b1;
        end
      end
    end
  end

`ifdef I2S_CLKGEN_MCLK_EN
  localparam int MW = (MCLK_HALF < 1) ? 1 : $clog2(MCLK_HALF + 1);
  logic [MW-1:0] mclk_cnt;

  // Free-running master clock, independent of en and the FSM.
  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      mclk_cnt <= '0;
      mclk     <= 1'b0;
    end else if (mclk_cnt >= MW'(MCLK_HALF)) begin
      mclk_cnt <= '0;
      mclk     <= ~mclk;
    end else begin
      mclk_cnt <= mclk_cnt + MW'(1);
    end
  end
`endif

endmodule
